// File: rtl/intensity_sort_pkg.sv
// Shared definitions for the dominant-channel pixel classifier.
//   BIN_*      : bit positions of the one-hot bin select (R, G, B)
//   *_MSB/LSB  : channel field positions inside a 24-bit RGB pixel
//   state_t    : frame sequencer states
package intensity_sort_pkg;

  localparam int unsigned BIN_R = 0;
  localparam int unsigned BIN_G = 1;
  localparam int unsigned BIN_B = 2;

  localparam int unsigned R_MSB = 23;
  localparam int unsigned R_LSB = 16;
  localparam int unsigned G_MSB = 15;
  localparam int unsigned G_LSB = 8;
  localparam int unsigned B_MSB = 7;
  localparam int unsigned B_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/dominant_channel_cmp.sv
// Combinational dominant-channel comparator.
// Ports:
//   pixel     : 24-bit RGB pixel, [23:16]=R, [15:8]=G, [7:0]=B
//   sel       : one-hot bin select, bit0=R, bit1=G, bit2=B
//   intensity : value of the dominant channel
// Ties resolve R over G over B, so sel is always exactly one-hot.
module dominant_channel_cmp
  import intensity_sort_pkg::*;
(
  input  logic [23:0] pixel,
  output logic [2:0]  sel,
  output logic [7:0]  intensity
);

  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;

  assign r = pixel[R_MSB:R_LSB];
  assign g = pixel[G_MSB:G_LSB];
  assign b = pixel[B_MSB:B_LSB];

  always_comb begin
    sel       = '0;
    intensity = '0;
    if (r >= g && r >= b) begin
      sel[BIN_R] = 1'b1;
      intensity  = r;
    end else if (g >= b) begin
      // R lost, so here g > r is already implied.
      sel[BIN_G] = 1'b1;
      intensity  = g;
    end else begin
      sel[BIN_B] = 1'b1;
      intensity  = b;
    end
  end

endmodule

// File: rtl/intensity_sort_ctrl.sv
// Frame-level sequencer for the dominant-channel pixel classifier.
// Accepts RGB pixels over valid/ready, classifies each into an R/G/B bin,
// emits it with a one-hot bin select and its dominant intensity, keeps
// per-bin counts for the frame and pulses done after the last pixel leaves.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : begins a frame (honoured only in IDLE)
//   in_valid/in_ready     : input handshake, in_pixel payload
//   out_valid/out_ready   : output handshake, out_pixel/out_sel/out_intensity
//   cnt_r/cnt_g/cnt_b     : per-bin counts for the current or last frame
//   busy                  : high in RUN and DRAIN
//   done                  : one-cycle pulse when the frame completes
// Optional build macro INTENSITY_THRESH_EN adds thresh (sampled on start)
// and cnt_dark; pixels whose dominant intensity is below thresh are
// emitted with out_sel=0, out_intensity=0 and counted in cnt_dark.
module intensity_sort_ctrl
  import intensity_sort_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      out_pixel,
  output logic [2:0]       out_sel,
  output logic [7:0]       out_intensity,
  output logic [CNT_W-1:0] cnt_r,
  output logic [CNT_W-1:0] cnt_g,
  output logic [CNT_W-1:0] cnt_b,
  output logic             busy,
  output logic             done
`ifdef INTENSITY_THRESH_EN
  ,
  input  logic [7:0]       thresh,
  output logic [CNT_W-1:0] cnt_dark
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] emit;

  logic       in_hs;
  logic       out_hs;
  logic       start_ok;
  logic [2:0] cmp_sel;
  logic [7:0] cmp_int;
  logic [2:0] cls_sel;
  logic [7:0] cls_int;

  dominant_channel_cmp u_cmp (
    .pixel     (in_pixel),
    .sel       (cmp_sel),
    .intensity (cmp_int)
  );

  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign start_ok = (state == IDLE) && start;

`ifdef INTENSITY_THRESH_EN
  logic [7:0] thresh_q;
  logic       dark;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_q <= '0;
    end else if (start_ok) begin
      thresh_q <= thresh;
    end
  end

  assign dark    = cmp_int < thresh_q;
  assign cls_sel = dark ? '0 : cmp_sel;
  assign cls_int = dark ? '0 : cmp_int;
`else
  assign cls_sel = cmp_sel;
  assign cls_int = cmp_int;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (in_hs && acc == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   if (out_hs && emit == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = (state == RUN) && (!out_valid || out_ready);
    busy     = (state != IDLE);
  end

  // Output register, frame counters and per-bin counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_pixel     <= '0;
      out_sel       <= '0;
      out_intensity <= '0;
      acc           <= '0;
      emit          <= '0;
      cnt_r         <= '0;
      cnt_g         <= '0;
      cnt_b         <= '0;
      done          <= 1'b0;
`ifdef INTENSITY_THRESH_EN
      cnt_dark      <= '0;
`endif
    end else begin
      done <= (state == DRAIN) && out_hs && (emit == LAST_IDX);

      if (start_ok) begin
        acc   <= '0;
        emit  <= '0;
        cnt_r <= '0;
        cnt_g <= '0;
        cnt_b <= '0;
`ifdef INTENSITY_THRESH_EN
        cnt_dark <= '0;
`endif
      end

      if (in_hs) begin
        out_valid     <= 1'b1;
        out_pixel     <= in_pixel;
        out_sel       <= cls_sel;
        out_intensity <= cls_int;
        acc           <= acc + CNT_W'(1);
        if (cls_sel[BIN_R]) cnt_r <= cnt_r + CNT_W'(1);
        if (cls_sel[BIN_G]) cnt_g <= cnt_g + CNT_W'(1);
        if (cls_sel[BIN_B]) cnt_b <= cnt_b + CNT_W'(1);
`ifdef INTENSITY_THRESH_EN
        if (cls_sel == 3'b000) cnt_dark <= cnt_dark + CNT_W'(1);
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (out_hs) begin
        emit <= emit + CNT_W'(1);
      end
    end
  end

endmodule
